// File: rtl/serial_fixed_accumulator_pkg.sv
// fixed_pkg: Q-format constants, FSM state type and a saturate helper shared by the fixed-point adders
package fixed_pkg;
    localparam int Q_DATA_WIDTH = 16;
    localparam int Q_FRACT_WIDTH = 8;
    localparam logic signed [Q_DATA_WIDTH-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [Q_DATA_WIDTH-1:0] Q_MIN = 16'sh8000;
    localparam int Q_SAT_W = Q_DATA_WIDTH + 8;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    typedef struct packed {
        logic sat;
        logic [Q_DATA_WIDTH-1:0] data;
    } sat_t;
    function automatic int acc_width(input int dw, input int n);
        return dw + $clog2(n) + 1;
    endfunction
    function automatic sat_t saturate(input logic signed [Q_SAT_W-1:0] v);
        sat_t r;
        r.sat = (v > Q_SAT_W'(Q_MAX)) || (v < Q_SAT_W'(Q_MIN));
        r.data = (v > Q_SAT_W'(Q_MAX)) ? Q_MAX : (v < Q_SAT_W'(Q_MIN)) ? Q_MIN : v[Q_DATA_WIDTH-1:0];
        return r;
    endfunction
endpackage

// File: rtl/serial_fixed_accumulator_if.sv
// serial_fixed_accumulator_if: operand stream in, saturated result stream out, plus synchronous abort
interface serial_fixed_accumulator_if #(parameter int DATA_WIDTH = 16);
    logic clear;
    logic [DATA_WIDTH-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic out_sat;
    logic out_valid;
    logic out_ready;
    modport master (output clear, in_data, in_valid, out_ready, input in_ready, out_data, out_sat, out_valid);
    modport slave (input clear, in_data, in_valid, out_ready, output in_ready, out_data, out_sat, out_valid);
endinterface

// File: rtl/serial_fixed_accumulator_saturate.sv
// fixed_saturate: clips a wide signed sum to DATA_WIDTH, flagging when clipping happened
module fixed_saturate #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_W = 19
) (
    input  logic signed [ACC_W-1:0]      sum,
    output logic        [DATA_WIDTH-1:0] data,
    output logic                         sat
);
    logic [ACC_W-DATA_WIDTH:0] top;
    assign top = sum[ACC_W-1:DATA_WIDTH-1];
    // in range only when every bit above the result MSB repeats the sign
    assign sat = !((&top) || !(|top));
    assign data = sat ? {sum[ACC_W-1], {(DATA_WIDTH-1){!sum[ACC_W-1]}}} : sum[DATA_WIDTH-1:0];
endmodule

// File: rtl/serial_fixed_accumulator.sv
// serial_fixed_accumulator: sums N_IN serially delivered fixed-point operands into one saturated result
module serial_fixed_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int N_IN = 3
) (
    input logic clk,
    input logic rst,
    serial_fixed_accumulator_if.slave bus
);
    import fixed_pkg::*;
    localparam int ACC_W = acc_width(DATA_WIDTH, N_IN);
    localparam int CNT_W = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);
    if (N_IN < 1 || FRACT_WIDTH > DATA_WIDTH) begin : g_bad_params
        $error("serial_fixed_accumulator: illegal N_IN or FRACT_WIDTH");
    end
    state_t state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, op, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, sat_data;
    logic out_sat_q, out_sat_d, sat_flag, accept;
    assign bus.in_ready = state_q != DONE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_data = out_data_q;
    assign bus.out_sat = out_sat_q;
    assign op = ACC_W'($signed(bus.in_data));
    // acc is held at zero in IDLE, so the first operand needs no special path
    assign sum = acc_q + op;
    assign accept = bus.in_valid && state_q != DONE;
    fixed_saturate #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(ACC_W)) u_sat (
        .sum (sum),
        .data(sat_data),
        .sat (sat_flag)
    );
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_data_d = out_data_q;
        out_sat_d = out_sat_q;
        if (bus.clear) begin
            state_d = IDLE;
            acc_d = '0;
            cnt_d = '0;
        end else if (accept && cnt_q == LAST) begin
            state_d = DONE;
            acc_d = '0;
            cnt_d = '0;
            out_data_d = sat_data;
            out_sat_d = sat_flag;
        end else if (accept) begin
            state_d = ACCUM;
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            cnt_q <= '0;
            out_data_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_serial_fixed_accumulator.sv
// tb_serial_fixed_accumulator: vector table plus corner sequences, results checked through a scoreboard queue
module tb_serial_fixed_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_fixed_accumulator_if #(.DATA_WIDTH(16)) bus3 ();
    serial_fixed_accumulator_if #(.DATA_WIDTH(16)) bus1 ();

    serial_fixed_accumulator #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .N_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    serial_fixed_accumulator #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .N_IN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] exp;
        logic        sat;
    } vec_t;
    vec_t vt[10];

    int vectors = 0;
    int miscompares = 0;
    logic [16:0] exp_q[$];
    logic [16:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        int n = 0;
        bus3.in_data = d;
        bus3.in_valid = 1'b1;
        while (!bus3.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus3.out_valid && bus3.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got %h expected none", bus3.out_data);
            end else begin
                e = exp_q.pop_front();
                check("result_data", {16'd0, bus3.out_data}, {16'd0, e[15:0]});
                check("result_sat", {31'd0, bus3.out_sat}, {31'd0, e[16]});
            end
        end
    end

    initial begin
        vt[0] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0200, 1'b0};
        vt[1] = '{16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 1'b1};
        vt[2] = '{16'h9000, 16'h9000, 16'h9000, 16'h8000, 1'b1};
        vt[3] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b0};
        vt[4] = '{16'h7FFF, 16'h0001, 16'hFFFF, 16'h7FFF, 1'b0};
        vt[5] = '{16'h8000, 16'hFFFF, 16'h0001, 16'h8000, 1'b0};
        vt[6] = '{16'h7FFF, 16'h0001, 16'h0000, 16'h7FFF, 1'b1};
        vt[7] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b1};
        vt[8] = '{16'h1234, 16'h0F00, 16'hFFFF, 16'h2133, 1'b0};
        vt[9] = '{16'hFF80, 16'hFF80, 16'hFF80, 16'hFE80, 1'b0};
        {bus3.clear, bus3.in_valid, bus3.in_data, bus3.out_ready} = {1'b0, 1'b0, 16'h0, 1'b1};
        {bus1.clear, bus1.in_valid, bus1.in_data, bus1.out_ready} = {1'b0, 1'b0, 16'h0, 1'b1};
        #2;
        check("reset_out_valid", {31'd0, bus3.out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, bus3.in_ready}, 32'd1);
        check("reset_out_data", {16'd0, bus3.out_data}, 32'd0);
        check("reset_out_sat", {31'd0, bus3.out_sat}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            send(vt[i].a);
            send(vt[i].b);
            exp_q.push_back({vt[i].sat, vt[i].exp});
            send(vt[i].c);
            check("latency_valid", {31'd0, bus3.out_valid}, 32'd1);
            check("done_in_ready", {31'd0, bus3.in_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("single_cycle_valid", {31'd0, bus3.out_valid}, 32'd0);
        end
        bus3.in_valid = 1'b0;
        bus3.out_ready = 1'b0;
        send(16'h0100);
        send(16'h0100);
        exp_q.push_back({1'b0, 16'h0300});
        send(16'h0100);
        bus3.in_data = 16'h0500;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, bus3.out_valid}, 32'd1);
            check("bp_out_data", {16'd0, bus3.out_data}, 32'h0300);
            check("bp_in_ready", {31'd0, bus3.in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus3.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'd0, bus3.out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, bus3.in_ready}, 32'd1);
        send(16'h0500);
        send(16'h0500);
        exp_q.push_back({1'b0, 16'h0F00});
        send(16'h0500);
        check("bp_next_valid", {31'd0, bus3.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        send(16'h0100);
        bus3.in_data = 16'h0200;
        bus3.clear = 1'b1;
        @(posedge clk);
        #1;
        {bus3.clear, bus3.in_valid} = 2'b00;
        check("clear_out_valid", {31'd0, bus3.out_valid}, 32'd0);
        check("clear_in_ready", {31'd0, bus3.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(16'h0080);
        send(16'h0080);
        exp_q.push_back({1'b0, 16'h0180});
        send(16'h0080);
        check("after_clear_valid", {31'd0, bus3.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus3.out_ready = 1'b0;
        send(16'h1000);
        send(16'h1000);
        send(16'h1000);
        bus3.in_valid = 1'b0;
        check("done_before_clear", {31'd0, bus3.out_valid}, 32'd1);
        bus3.clear = 1'b1;
        @(posedge clk);
        #1;
        bus3.clear = 1'b0;
        check("clear_done_valid", {31'd0, bus3.out_valid}, 32'd0);
        check("clear_done_data_held", {16'd0, bus3.out_data}, 32'h3000);
        check("clear_done_ready", {31'd0, bus3.in_ready}, 32'd1);
        bus3.out_ready = 1'b1;
        send(16'h0100);
        send(16'h0200);
        bus3.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_data", {16'd0, bus3.out_data}, 32'd0);
        check("arst_out_sat", {31'd0, bus3.out_sat}, 32'd0);
        check("arst_out_valid", {31'd0, bus3.out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, bus3.in_ready}, 32'd1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send(16'h0100);
        send(16'h0100);
        exp_q.push_back({1'b0, 16'h0100});
        send(16'hFF00);
        check("after_rst_valid", {31'd0, bus3.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        {bus1.in_data, bus1.in_valid} = {16'h1234, 1'b1};
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        check("n1_out_valid", {31'd0, bus1.out_valid}, 32'd1);
        check("n1_out_data", {16'd0, bus1.out_data}, 32'h1234);
        check("n1_out_sat", {31'd0, bus1.out_sat}, 32'd0);
        @(posedge clk);
        #1;
        check("n1_valid_drop", {31'd0, bus1.out_valid}, 32'd0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
